// File: rtl/autocorrelation_engine.sv
// Frame autocorrelation engine: computes R(0)..R(K) one lag per pass over a synchronous frame buffer.
// Optional build macro AUTOCORR_SAT_EN: saturate y to the signed OUT_W range instead of truncating.
module autocorrelation_engine #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 240,
  parameter int ADDR_W    = 8,
  parameter int ORDER     = 10,
  parameter int LAG_W     = 4,
  parameter int ACC_W     = 40,
  parameter int OUT_W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LAG_W-1:0]         order,
  output logic                     busy,
  output logic                     done,
  output logic                     y_valid,
  output logic signed [OUT_W-1:0]  y,
  output logic [ORDER:0]           wsel,
  output logic [ADDR_W-1:0]        raddr,
  input  logic signed [DATA_W-1:0] x
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_DRAIN = ADDR_W'(1);
  localparam logic [LAG_W-1:0]  ORDER_L    = LAG_W'(ORDER);
`ifdef AUTOCORR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, WRITE, FINISH} state_t;

  state_t                     state, state_nxt;
  logic [ADDR_W-1:0]          cnt;
  logic [LAG_W-1:0]           k, kmax;
  logic                       lag_start, last_addr, last_drain;
  logic signed [DATA_W-1:0]   dl [ORDER];
  logic signed [DATA_W-1:0]   lag_op_p0;
  logic                       vld_p1, vld_p2;
  logic signed [PROD_W-1:0]   prod_p1;
  logic signed [ACC_W-1:0]    acc_p2;
  logic signed [OUT_W-1:0]    y_hold;

  function automatic logic signed [OUT_W-1:0] reduce_acc(input logic signed [ACC_W-1:0] a);
`ifdef AUTOCORR_SAT_EN
    if (a > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (a < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    else                  return a[OUT_W-1:0];
`else
    return a[OUT_W-1:0];
`endif
  endfunction

  assign last_addr  = (cnt == LAST_ADDR);
  assign last_drain = (cnt == LAST_DRAIN);
  // k never exceeds kmax, so inequality means another lag remains
  assign lag_start  = ((state == IDLE) && start) || ((state == WRITE) && (k != kmax));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (last_addr) state_nxt = DRAIN;
      DRAIN:   if (last_drain) state_nxt = WRITE;
      WRITE:   state_nxt = (k != kmax) ? STREAM : FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == STREAM) || (state == DRAIN) || (state == WRITE);
    done    = (state == FINISH);
    y_valid = (state == WRITE);
    wsel    = y_valid ? ({{ORDER{1'b0}}, 1'b1} << k) : '0;
    raddr   = (state == STREAM) ? cnt : '0;
    y       = y_valid ? reduce_acc(acc_p2) : y_hold;
  end

  always_comb begin
    lag_op_p0 = x;
    for (int i = 1; i <= ORDER; i++)
      if (k == LAG_W'(i)) lag_op_p0 = dl[i-1];
  end

  // p0 -> p1: sample arrives, delay line shifts, product registered
  always_ff @(posedge clk) begin
    if (vld_p1) prod_p1 <= PROD_W'(x) * PROD_W'(lag_op_p0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      k      <= '0;
      kmax   <= '0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      acc_p2 <= '0;
      y_hold <= '0;
      for (int i = 0; i < ORDER; i++) dl[i] <= '0;
    end else begin
      vld_p1 <= (state == STREAM);
      vld_p2 <= vld_p1;
      if (((state == STREAM) && !last_addr) || ((state == DRAIN) && !last_drain))
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
      if ((state == IDLE) && start) begin
        kmax <= (order > ORDER_L) ? ORDER_L : order;
        k    <= '0;
      end else if (lag_start) begin
        k <= k + 1'b1;
      end
      // p1 -> p2: accumulate; every lag begins from a zeroed history
      if (lag_start) begin
        acc_p2 <= '0;
        for (int i = 0; i < ORDER; i++) dl[i] <= '0;
      end else begin
        if (vld_p2) acc_p2 <= acc_p2 + ACC_W'(prod_p1);
        if (vld_p1) begin
          dl[0] <= x;
          for (int i = 1; i < ORDER; i++) dl[i] <= dl[i-1];
        end
      end
      if (state == WRITE) y_hold <= reduce_acc(acc_p2);
    end
  end

endmodule

// File: tb/tb_autocorrelation_engine.sv
// Directed bench for autocorrelation_engine: frame-buffer model, reference R(k) model and result scoreboard.
module tb_autocorrelation_engine;

  localparam int N = 240;
  localparam int LAG_PERIOD = N + 3;

  typedef struct packed {
    logic [10:0] w;
    logic [31:0] y;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  order;
  logic        busy, done, y_valid;
  logic [31:0] y;
  logic [10:0] wsel;
  logic [7:0]  raddr;
  logic [15:0] x = '0;

  logic signed [15:0] mem [0:255];
  exp_t exp_q [$];
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  logic [31:0] last_y;

  autocorrelation_engine dut (
    .clk(clk), .reset(reset), .start(start), .order(order),
    .busy(busy), .done(done), .y_valid(y_valid), .y(y),
    .wsel(wsel), .raddr(raddr), .x(x)
  );

  always #5 clk = ~clk;

  // synchronous frame buffer: data follows the address by one cycle
  always @(posedge clk) x <= mem[raddr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (y_valid) begin
      exp_t e;
      pulses++;
      chk("y_valid_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("y", 64'(y), 64'(e.y));
        chk("wsel", 64'(wsel), 64'(e.w));
      end
    end
  end

  function automatic logic [31:0] model_y(input longint r);
`ifdef AUTOCORR_SAT_EN
    if (r > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (r < -64'sd2147483648) return 32'h8000_0000;
`endif
    return r[31:0];
  endfunction

  task automatic push_expected(input int ord, output int kc);
    longint r;
    exp_t e;
    kc = (ord > 10) ? 10 : ord;
    for (int k = 0; k <= kc; k++) begin
      r = 0;
      for (int n = k; n < N; n++) r += longint'(mem[n]) * longint'(mem[n-k]);
      e.w = 11'd1 << k;
      e.y = model_y(r);
      exp_q.push_back(e);
      last_y = e.y;
    end
  endtask

  task automatic run_frame(input string tag, input int ord, input bit inject);
    int kc, edges;
    pulses = 0;
    push_expected(ord, kc);
    @(posedge clk); #1 order = 4'(ord); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    edges = 0;
    while (!done && edges < 4000) begin
      @(posedge clk); #1 edges++;
      start = (inject && edges == 500);
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    chk({tag, "_latency"}, 64'(edges + 1), 64'(1 + (kc + 1) * LAG_PERIOD));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_pulses"}, 64'(pulses), 64'(kc + 1));
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_y_hold"}, 64'(y), 64'(last_y));
    chk({tag, "_raddr_idle"}, 64'(raddr), 64'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_y_valid"}, 64'(y_valid), 64'd0);
    chk({tag, "_y"}, 64'(y), 64'd0);
    chk({tag, "_wsel"}, 64'(wsel), 64'd0);
    chk({tag, "_raddr"}, 64'(raddr), 64'd0);
  endtask

  initial begin
    int kc, guard;
    reset = 1'b0; start = 1'b0; order = '0;
    for (int n = 0; n < 256; n++) mem[n] = 16'sd1;
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");
    reset = 1'b1;
    repeat (2) @(posedge clk);

    run_frame("ones_o10", 10, 1'b0);

    for (int n = 0; n < 256; n++) mem[n] = (n % 2 == 0) ? 16'sd1 : -16'sd1;
    run_frame("alt_o3", 3, 1'b0);

    for (int n = 0; n < 256; n++) mem[n] = -16'sd32768;
    run_frame("min_o0", 0, 1'b0);

    for (int n = 0; n < 256; n++) mem[n] = 16'($urandom);
    run_frame("rand_o15", 15, 1'b0);

    for (int n = 0; n < 256; n++) mem[n] = 16'($urandom_range(0, 2000)) - 16'sd1000;
    run_frame("start_busy_o2", 2, 1'b1);

    // abort during lag 3 streaming
    for (int n = 0; n < 256; n++) mem[n] = 16'sd1;
    pulses = 0;
    push_expected(10, kc);
    @(posedge clk); #1 order = 4'd10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    guard = 0;
    while (pulses < 3 && guard < 2000) begin @(posedge clk); guard++; end
    chk("abort_reached_lag3", 64'(pulses), 64'd3);
    repeat (50) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_zero_outputs("abort");
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b1;
    pulses = 0;
    repeat (300) @(posedge clk);
    #1;
    chk("post_abort_no_pulse", 64'(pulses), 64'd0);
    check_zero_outputs("post_abort");

    run_frame("fresh_o10", 10, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
